// File: rtl/bp_me_mem_responder.sv
// bp_me_mem_responder
//   Far end of the ME interface for single-core bring-up: accepts one line
//   read or write at a time, keeps a small line-granular backing store and
//   returns a single response a fixed number of cycles after acceptance.
//
//   Timing: a request accepted at edge t is presented so that resp_v_o is
//   sampled high at edge t+latency_p (the FSM enters RESP at edge
//   t+latency_p-1). Writes commit to the store at the acceptance edge, so a
//   following read of the same line always observes them.
//
//   Ports
//     clk_i, reset_i            clock, asynchronous active-high reset
//     req_v_i / req_ready_o     request handshake (ready = FSM idle)
//     req_we_i, req_addr_i      write flag and line address (offset ignored)
//     req_data_i                write data
//     resp_v_o / resp_yumi_i    response valid / consumed
//     resp_we_o, resp_addr_o    echoes of the accepted request
//     resp_data_o               read data, 0 for writes
//     resp_err_o                out-of-range flag (macro builds only)
//
//   Optional feature: define BP_ME_MEM_RANGE_CHECK_EN to add resp_err_o and
//   reject addresses whose bits above the store index are non-zero (no
//   store write, zero data, err=1, same timing). Without it, those bits alias.
module bp_me_mem_responder #(
  parameter int paddr_width_p = 22,
  parameter int data_width_p  = 512,
  parameter int lg_lines_p    = 6,
  parameter int latency_p     = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     req_v_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [paddr_width_p-1:0] req_addr_i,
  input  logic [data_width_p-1:0]  req_data_i,
  output logic                     resp_v_o,
  input  logic                     resp_yumi_i,
  output logic                     resp_we_o,
  output logic [paddr_width_p-1:0] resp_addr_o,
  output logic [data_width_p-1:0]  resp_data_o
`ifdef BP_ME_MEM_RANGE_CHECK_EN
  , output logic                   resp_err_o
`endif
);

  localparam int off_lp   = $clog2(data_width_p/8);
  localparam int lines_lp = 1 << lg_lines_p;
  localparam int cnt_w_lp = (latency_p > 2) ? $clog2(latency_p-1) : 1;
  localparam logic [cnt_w_lp-1:0] cnt_init_lp =
    (latency_p > 1) ? cnt_w_lp'(latency_p-2) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  typedef struct packed {
    logic                     we;
    logic                     oor;
    logic [paddr_width_p-1:0] addr;
  } req_s;

  state_e                  state;
  logic [cnt_w_lp-1:0]     cnt;
  req_s                    req_r;
  logic [data_width_p-1:0] mem [lines_lp];

  logic                    accept;
  logic                    req_oor;
  logic [lg_lines_p-1:0]   acc_idx;
  logic [lg_lines_p-1:0]   held_idx;

`ifdef BP_ME_MEM_RANGE_CHECK_EN
  assign req_oor = |req_addr_i[paddr_width_p-1:off_lp+lg_lines_p];
`else
  assign req_oor = 1'b0;
`endif

  assign req_ready_o = (state == IDLE);
  assign accept      = req_v_i & req_ready_o;
  assign acc_idx     = req_addr_i[off_lp +: lg_lines_p];
  assign held_idx    = req_r.addr[off_lp +: lg_lines_p];

  // Backing store: not reset; write lands on the acceptance edge.
  always_ff @(posedge clk_i)
    if (accept && req_we_i && !req_oor)
      mem[acc_idx] <= req_data_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      cnt         <= '0;
      req_r       <= '0;
      resp_v_o    <= 1'b0;
      resp_we_o   <= 1'b0;
      resp_addr_o <= '0;
      resp_data_o <= '0;
`ifdef BP_ME_MEM_RANGE_CHECK_EN
      resp_err_o  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (req_v_i) begin
          req_r <= '{we: req_we_i, oor: req_oor, addr: req_addr_i};
          cnt   <= cnt_init_lp;
          if (latency_p == 1) begin
            // Single-cycle latency: respond straight from the request port.
            // A read sees the pre-edge store contents, which is correct
            // since only writes update the store.
            state       <= RESP;
            resp_v_o    <= 1'b1;
            resp_we_o   <= req_we_i;
            resp_addr_o <= req_addr_i;
            resp_data_o <= (req_we_i || req_oor) ? '0 : mem[acc_idx];
`ifdef BP_ME_MEM_RANGE_CHECK_EN
            resp_err_o  <= req_oor;
`endif
          end else begin
            state <= WAIT;
          end
        end
        WAIT: if (cnt == '0) begin
          state       <= RESP;
          resp_v_o    <= 1'b1;
          resp_we_o   <= req_r.we;
          resp_addr_o <= req_r.addr;
          resp_data_o <= (req_r.we || req_r.oor) ? '0 : mem[held_idx];
`ifdef BP_ME_MEM_RANGE_CHECK_EN
          resp_err_o  <= req_r.oor;
`endif
        end else begin
          cnt <= cnt - 1'b1;
        end
        RESP: if (resp_yumi_i) begin
          state    <= IDLE;
          resp_v_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
